// File: rtl/pulse_capture.sv
// pulse_capture: input-capture timer for an external digital waveform.
// It measures, in prescaled clock ticks, the time from a rising edge to the
// next falling edge (high_time) and from that rising edge to the next rising
// edge (period). Each completed measurement is offered on a valid/ready
// handshake.
//
// Parameters
//   WIDTH : width of the measurement counter and result outputs
//   DIV   : prescaler bits; one count tick every 2^DIV clk cycles
//
// Ports
//   clk           : system clock
//   rst           : asynchronous active-low reset
//   enable        : measurement enable; low forces IDLE and clears status
//   signal_in     : asynchronous waveform to measure
//   capture_valid : result registers hold an unconsumed measurement
//   capture_ready : consumer accepts the result on a clk edge with valid=1
//   high_time     : ticks from rising edge to falling edge
//   period        : ticks from rising edge to next rising edge
//   overflow      : counter saturated during the reported measurement
//   missed        : sticky; a completed result was dropped while one was pending
//   busy          : a measurement is in progress (MEAS_HIGH or MEAS_LOW)
module pulse_capture #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIV   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             signal_in,
    output logic             capture_valid,
    input  logic             capture_ready,
    output logic [WIDTH-1:0] high_time,
    output logic [WIDTH-1:0] period,
    output logic             overflow,
    output logic             missed,
    output logic             busy
);

    // A zero-bit prescaler is not legal, so DIV=0 keeps one constant-zero bit.
    localparam int unsigned PSC_W = (DIV > 0) ? DIV : 1;
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'((64'd1 << DIV) - 64'd1);
    localparam logic [WIDTH-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RISE = 2'd1,
        MEAS_HIGH = 2'd2,
        MEAS_LOW  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic               sync1_q, sync2_q, prev_q;
    logic [PSC_W-1:0]   psc_q, psc_d;
    logic [WIDTH-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   high_time_q, high_time_d;
    logic [WIDTH-1:0]   period_q, period_d;
    logic               overflow_q, overflow_d;
    logic               valid_q, valid_d;
    logic               missed_q, missed_d;
    logic               busy_q, busy_d;

    logic               rise_c, fall_c;
    logic               tick_c, sat_c;
    logic [WIDTH-1:0]   cnt_inc_c;
    logic               ovf_inc_c;
    logic               complete_c;

    // Edge detection on the synchronized signal; runs in every state.
    assign rise_c = sync2_q & ~prev_q;
    assign fall_c = ~sync2_q & prev_q;

    // Registers represent the elapsed cycles minus one since the starting
    // rise, so the incremented value is the count including this cycle.
    assign tick_c    = (psc_q == PSC_LAST);
    assign sat_c     = tick_c && (cnt_q == CNT_MAX);
    assign cnt_inc_c = (tick_c && !sat_c) ? cnt_q + WIDTH'(1) : cnt_q;
    assign ovf_inc_c = ovf_q | sat_c;

    // Next-state, counter and result-handshake logic.
    always_comb begin
        state_d     = state_q;
        psc_d       = psc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        hi_d        = hi_q;
        high_time_d = high_time_q;
        period_d    = period_q;
        overflow_d  = overflow_q;
        valid_d     = valid_q;
        missed_d    = missed_q;
        complete_c  = 1'b0;

        if (!enable) begin
            // Result registers are kept; only status and measurement clear.
            state_d  = IDLE;
            psc_d    = '0;
            cnt_d    = '0;
            ovf_d    = 1'b0;
            valid_d  = 1'b0;
            missed_d = 1'b0;
        end else begin
            if (valid_q && capture_ready) begin
                valid_d = 1'b0;
            end

            case (state_q)
                IDLE: begin
                    state_d = WAIT_RISE;
                end
                WAIT_RISE: begin
                    if (rise_c) begin
                        state_d = MEAS_HIGH;
                        psc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                MEAS_HIGH: begin
                    psc_d = tick_c ? '0 : psc_q + PSC_W'(1);
                    cnt_d = cnt_inc_c;
                    ovf_d = ovf_inc_c;
                    if (fall_c) begin
                        hi_d    = cnt_inc_c;
                        state_d = MEAS_LOW;
                    end
                end
                MEAS_LOW: begin
                    psc_d = tick_c ? '0 : psc_q + PSC_W'(1);
                    cnt_d = cnt_inc_c;
                    ovf_d = ovf_inc_c;
                    if (rise_c) begin
                        // This rise closes one measurement and opens the next.
                        complete_c = 1'b1;
                        psc_d      = '0;
                        cnt_d      = '0;
                        ovf_d      = 1'b0;
                        state_d    = MEAS_HIGH;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            if (complete_c) begin
                if (!valid_q || capture_ready) begin
                    high_time_d = hi_q;
                    period_d    = cnt_inc_c;
                    overflow_d  = ovf_inc_c;
                    valid_d     = 1'b1;
                end else begin
                    missed_d = 1'b1;
                end
            end
        end

        busy_d = (state_d == MEAS_HIGH) || (state_d == MEAS_LOW);
    end

    // State, synchronizer and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            prev_q      <= 1'b0;
            psc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            hi_q        <= '0;
            high_time_q <= '0;
            period_q    <= '0;
            overflow_q  <= 1'b0;
            valid_q     <= 1'b0;
            missed_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= signal_in;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            psc_q       <= psc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            hi_q        <= hi_d;
            high_time_q <= high_time_d;
            period_q    <= period_d;
            overflow_q  <= overflow_d;
            valid_q     <= valid_d;
            missed_q    <= missed_d;
            busy_q      <= busy_d;
        end
    end

    assign capture_valid = valid_q;
    assign high_time     = high_time_q;
    assign period        = period_q;
    assign overflow      = overflow_q;
    assign missed        = missed_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_pulse_capture.sv
// Bench for pulse_capture: three instances (WIDTH/DIV = 16/0, 16/2, 4/0)
// share clock, reset, enable and ready, each with its own waveform input.
// Expected results are queued as waveforms are driven and compared when the
// DUT hands a result over.
module tb_pulse_capture;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        capture_ready;
    logic [2:0]  sig;

    logic        v0, v1, v2;
    logic [15:0] ht0, per0, ht1, per1;
    logic [3:0]  ht2, per2;
    logic        ovf0, ovf1, ovf2;
    logic        mis0, mis1, mis2;
    logic        busy0, busy1, busy2;

    typedef struct {
        int unsigned high;
        int unsigned per;
        int unsigned ovf;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    exp_t        q2[$];

    int unsigned errors;
    int unsigned checks;

    pulse_capture #(.WIDTH(16), .DIV(0)) u_dut (
        .clk(clk), .rst(rst), .enable(enable), .signal_in(sig[0]),
        .capture_valid(v0), .capture_ready(capture_ready),
        .high_time(ht0), .period(per0), .overflow(ovf0),
        .missed(mis0), .busy(busy0)
    );

    pulse_capture #(.WIDTH(16), .DIV(2)) u_div2 (
        .clk(clk), .rst(rst), .enable(enable), .signal_in(sig[1]),
        .capture_valid(v1), .capture_ready(capture_ready),
        .high_time(ht1), .period(per1), .overflow(ovf1),
        .missed(mis1), .busy(busy1)
    );

    pulse_capture #(.WIDTH(4), .DIV(0)) u_w4 (
        .clk(clk), .rst(rst), .enable(enable), .signal_in(sig[2]),
        .capture_valid(v2), .capture_ready(capture_ready),
        .high_time(ht2), .period(per2), .overflow(ovf2),
        .missed(mis2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input int unsigned h, input int unsigned p,
                                   input int unsigned div, input int unsigned w);
        exp_t        e;
        int unsigned mx;
        int unsigned th;
        int unsigned tp;
        mx     = (32'd1 << w) - 32'd1;
        th     = h >> div;
        tp     = p >> div;
        e.high = (th > mx) ? mx : th;
        e.per  = (tp > mx) ? mx : tp;
        e.ovf  = (tp > mx) ? 1 : 0;
        return e;
    endfunction

    function automatic int unsigned qsize(input int sel);
        case (sel)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic push_exp(input int sel, input exp_t e);
        case (sel)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    // Inputs change 2 time units after each rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Drives n periods of high h / low l, each closed by a rising edge.
    task automatic wave(input int sel, input int h, input int l, input int n, input bit push);
        int unsigned div;
        int unsigned w;
        div = (sel == 1) ? 2 : 0;
        w   = (sel == 2) ? 4 : 16;
        if (push) begin
            for (int i = 0; i < n; i++) push_exp(sel, model(h, h + l, div, w));
        end
        if (sig[sel] == 1'b0) sig[sel] = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick(h);
            sig[sel] = 1'b0;
            tick(l);
            sig[sel] = 1'b1;
        end
    endtask

    task automatic drain(input int sel);
        for (int i = 0; i < 80 && qsize(sel) > 0; i++) tick(1);
        check_eq($sformatf("drain%0d", sel), qsize(sel), 0);
    endtask

    task automatic restart();
        sig = 3'b000;
        tick(6);
        enable = 1'b0;
        tick(2);
        check_eq("restart_missed", {31'd0, mis0}, 0);
        check_eq("restart_valid", {31'd0, v0}, 0);
        enable = 1'b1;
        tick(2);
    endtask

    task automatic score(input int sel, input logic [31:0] h, input logic [31:0] p, input logic o);
        exp_t e;
        if (qsize(sel) == 0) begin
            check_eq($sformatf("u%0d_unexpected_valid", sel), 1, 0);
        end else begin
            case (sel)
                0:       e = q0.pop_front();
                1:       e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
            check_eq($sformatf("u%0d_high_time", sel), h, e.high);
            check_eq($sformatf("u%0d_period", sel), p, e.per);
            check_eq($sformatf("u%0d_overflow", sel), {31'd0, o}, e.ovf);
        end
    endtask

    // Results are scored on the falling edge before the accepting rising edge.
    always @(negedge clk) begin
        if (rst && capture_ready) begin
            if (v0) score(0, 32'(ht0), 32'(per0), ovf0);
            if (v1) score(1, 32'(ht1), 32'(per1), ovf1);
            if (v2) score(2, 32'(ht2), 32'(per2), ovf2);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        errors        = 0;
        checks        = 0;
        rst           = 1'b0;
        enable        = 1'b0;
        capture_ready = 1'b1;
        sig           = 3'b000;

        // Reset values without any clock edge yet.
        #3;
        check_eq("rst_valid", {31'd0, v0}, 0);
        check_eq("rst_high_time", 32'(ht0), 0);
        check_eq("rst_period", 32'(per0), 0);
        check_eq("rst_overflow", {31'd0, ovf0}, 0);
        check_eq("rst_missed", {31'd0, mis0}, 0);
        check_eq("rst_busy", {31'd0, busy0}, 0);
        #5;
        rst    = 1'b1;
        enable = 1'b1;
        tick(3);

        // Basic measurement, high 3 / low 5.
        wave(0, 3, 5, 4, 1'b1);
        drain(0);
        check_eq("t1_missed", {31'd0, mis0}, 0);
        check_eq("t1_busy", {31'd0, busy0}, 1);
        restart();

        // Prescaler, DIV=2.
        wave(1, 12, 20, 2, 1'b1);
        drain(1);
        restart();

        // Saturation on a 4-bit counter, then a normal measurement.
        wave(2, 20, 10, 1, 1'b1);
        wave(2, 3, 5, 1, 1'b1);
        drain(2);
        restart();

        // Back-pressure: first result held, later ones dropped.
        capture_ready = 1'b0;
        push_exp(0, model(3, 8, 0, 16));
        wave(0, 3, 5, 1, 1'b0);
        wave(0, 4, 6, 2, 1'b0);
        tick(6);
        check_eq("t4_valid_held", {31'd0, v0}, 1);
        check_eq("t4_high_held", 32'(ht0), 3);
        check_eq("t4_period_held", 32'(per0), 8);
        check_eq("t4_missed", {31'd0, mis0}, 1);
        capture_ready = 1'b1;
        tick(1);
        capture_ready = 1'b0;
        check_eq("t4_valid_after_accept", {31'd0, v0}, 0);
        check_eq("t4_missed_sticky", {31'd0, mis0}, 1);
        check_eq("t4_queue_empty", qsize(0), 0);
        capture_ready = 1'b1;
        restart();

        // Enable drop mid-measurement, re-enable with the signal high.
        sig[0] = 1'b1;
        tick(5);
        check_eq("t5_busy_meas", {31'd0, busy0}, 1);
        enable = 1'b0;
        tick(1);
        check_eq("t5_busy_off", {31'd0, busy0}, 0);
        check_eq("t5_valid_off", {31'd0, v0}, 0);
        tick(3);
        enable = 1'b1;
        tick(6);
        check_eq("t5_no_rise_when_high", {31'd0, busy0}, 0);
        sig[0] = 1'b0;
        tick(4);
        check_eq("t5_still_idle_after_fall", {31'd0, busy0}, 0);
        wave(0, 3, 5, 1, 1'b1);
        drain(0);
        restart();

        // Asynchronous reset in MEAS_LOW with a pending result.
        capture_ready = 1'b0;
        wave(0, 3, 5, 1, 1'b0);
        tick(2);
        sig[0] = 1'b0;
        tick(6);
        check_eq("t6_pre_valid", {31'd0, v0}, 1);
        check_eq("t6_pre_busy", {31'd0, busy0}, 1);
        #1;
        rst = 1'b0;
        #1;
        check_eq("t6_valid", {31'd0, v0}, 0);
        check_eq("t6_high_time", 32'(ht0), 0);
        check_eq("t6_period", 32'(per0), 0);
        check_eq("t6_overflow", {31'd0, ovf0}, 0);
        check_eq("t6_missed", {31'd0, mis0}, 0);
        check_eq("t6_busy", {31'd0, busy0}, 0);
        #1;
        rst = 1'b1;
        tick(1);
        capture_ready = 1'b1;
        push_exp(0, model(10, 20, 0, 16));
        sig[0] = 1'b1;
        tick(10);
        check_eq("t6_no_result_after_rise", {31'd0, v0}, 0);
        sig[0] = 1'b0;
        tick(10);
        check_eq("t6_no_result_after_fall", {31'd0, v0}, 0);
        sig[0] = 1'b1;
        drain(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
